touch_pad_decoder: RTL and testbench



---
 rtl/touch_pad_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_touch_pad_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/touch_pad_decoder.sv
// touch_pad_decoder
//   Conditions raw, pulled-up, active-low pad/button inputs. Every channel is
//   independent: a two-flop synchronizer, then a debouncer, then a press
//   classification FSM that produces a clean level plus one-cycle events.
//
//   Optional feature macro: TOUCH_PAD_LONG_PRESS_EN
//     defined   : hold counter + LONG state, long_pulse and release_long live
//     undefined : IDLE/HELD FSM only, long_pulse and release_long tied to 0
//
// Ports
//   clk           in   system clock, rising edge
//   resetn        in   asynchronous active-low reset
//   pad_n         in   [N_PADS] raw pad levels, 0 = pressed, async to clk
//   pressed       out  [N_PADS] debounced level, 1 = pressed (registered)
//   press_pulse   out  [N_PADS] one-cycle pulse on debounced press
//   long_pulse    out  [N_PADS] one-cycle pulse when a press becomes long
//   release_pulse out  [N_PADS] one-cycle pulse on debounced release
//   release_long  out  [N_PADS] valid with release_pulse: 1 = press was long
module touch_pad_decoder #(
  parameter int N_PADS          = 2,
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int HOLD_CYCLES     = 24000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [N_PADS-1:0] pad_n,
  output logic [N_PADS-1:0] pressed,
  output logic [N_PADS-1:0] press_pulse,
  output logic [N_PADS-1:0] long_pulse,
  output logic [N_PADS-1:0] release_pulse,
  output logic [N_PADS-1:0] release_long
);

  localparam int DEB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

`ifdef TOUCH_PAD_LONG_PRESS_EN
  localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1
  } state_t;
`endif

  for (genvar g = 0; g < N_PADS; g++) begin : g_pad
    logic [1:0]       sync_r;
    logic             sync_n_s;
    logic             stable_r;
    logic [DEB_W-1:0] deb_cnt_r;
    state_t           state_r;
    state_t           state_s;
    logic             press_s;
    logic             rel_s;
    logic             pressed_r;
    logic             press_r;
    logic             rel_r;
`ifdef TOUCH_PAD_LONG_PRESS_EN
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              long_s;
    logic              rel_long_s;
    logic              long_r;
    logic              rel_long_r;
`endif

    assign sync_n_s = sync_r[1];

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        sync_r <= 2'b11;
      end else begin
        sync_r <= {sync_r[0], pad_n[g]};
      end
    end

    // Debouncer: a differing level must persist DEBOUNCE_CYCLES samples;
    // any bounce back to the stable level restarts the count from zero.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        stable_r  <= 1'b1;
        deb_cnt_r <= {DEB_W{1'b0}};
      end else if (sync_n_s == stable_r) begin
        stable_r  <= stable_r;
        deb_cnt_r <= {DEB_W{1'b0}};
      end else if (deb_cnt_r == DEB_LAST) begin
        stable_r  <= sync_n_s;
        deb_cnt_r <= {DEB_W{1'b0}};
      end else begin
        stable_r  <= stable_r;
        deb_cnt_r <= deb_cnt_r + DEB_W'(1);
      end
    end

    // Classifier state register.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_r <= ST_IDLE;
      end else begin
        state_r <= state_s;
      end
    end

    // Classifier next state and event decode. The FSM follows the stable
    // level, so its registered pulses line up with the registered level.
    // Release is tested before the hold threshold so it wins a tie.
    always_comb begin
      state_s = state_r;
      press_s = 1'b0;
      rel_s   = 1'b0;
`ifdef TOUCH_PAD_LONG_PRESS_EN
      long_s     = 1'b0;
      rel_long_s = 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          if (!stable_r) begin
            state_s = ST_HELD;
            press_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (stable_r) begin
            state_s = ST_IDLE;
            rel_s   = 1'b1;
          end
`ifdef TOUCH_PAD_LONG_PRESS_EN
          else if (hold_cnt_r == HOLD_LAST) begin
            state_s = ST_LONG;
            long_s  = 1'b1;
          end
`endif
          else begin
            state_s = ST_HELD;
          end
        end
`ifdef TOUCH_PAD_LONG_PRESS_EN
        ST_LONG: begin
          if (stable_r) begin
            state_s    = ST_IDLE;
            rel_s      = 1'b1;
            rel_long_s = 1'b1;
          end else begin
            state_s = ST_LONG;
          end
        end
`endif
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end

`ifdef TOUCH_PAD_LONG_PRESS_EN
    // Hold counter: zero while idle, counts in HELD, frozen in LONG.
    // It only advances while staying in HELD, so it can never wrap.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        hold_cnt_r <= {HOLD_W{1'b0}};
      end else if (state_r == ST_IDLE) begin
        hold_cnt_r <= {HOLD_W{1'b0}};
      end else if ((state_r == ST_HELD) && (state_s == ST_HELD)) begin
        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
      end else begin
        hold_cnt_r <= hold_cnt_r;
      end
    end

    // Long-press output registers.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        long_r     <= 1'b0;
        rel_long_r <= 1'b0;
      end else begin
        long_r     <= long_s;
        rel_long_r <= rel_long_s;
      end
    end

    assign long_pulse[g]   = long_r;
    assign release_long[g] = rel_long_r;
`else
    assign long_pulse[g]   = 1'b0;
    assign release_long[g] = 1'b0;
`endif

    // Level and press/release output registers.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        pressed_r <= 1'b0;
        press_r   <= 1'b0;
        rel_r     <= 1'b0;
      end else begin
        pressed_r <= ~stable_r;
        press_r   <= press_s;
        rel_r     <= rel_s;
      end
    end

    assign pressed[g]       = pressed_r;
    assign press_pulse[g]   = press_r;
    assign release_pulse[g] = rel_r;
  end

endmodule

// File: tb/tb_touch_pad_decoder.sv
// Directed bench for touch_pad_decoder with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
// Inputs change 1 ns after a rising edge; the edge right after a change is
// edge 1 of a scenario. Outputs are logged 1 ns after each edge and checked
// against hand-derived edge numbers.
module tb_touch_pad_decoder;
  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int LOGN = 128;

`ifdef TOUCH_PAD_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [N-1:0] pad_n = 2'b11;
  logic [N-1:0] pressed, press_pulse, long_pulse, release_pulse, release_long;

  touch_pad_decoder #(
    .N_PADS          (N),
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .pad_n         (pad_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .long_pulse    (long_pulse),
    .release_pulse (release_pulse),
    .release_long  (release_long)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // per-edge log: index = edge number within the current scenario
  logic [N-1:0] lg [0:4][0:LOGN-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic start();
    cyc = 0;
    for (int s = 0; s < 5; s++)
      for (int k = 0; k < LOGN; k++)
        lg[s][k] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < LOGN) begin
      lg[0][cyc] = pressed;
      lg[1][cyc] = press_pulse;
      lg[2][cyc] = long_pulse;
      lg[3][cyc] = release_pulse;
      lg[4][cyc] = release_long;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // sel: 0 pressed, 1 press_pulse, 2 long_pulse, 3 release_pulse, 4 release_long
  function automatic int first_hi(input int sel, input int pad);
    for (int k = 1; k < LOGN; k++)
      if (lg[sel][k][pad] === 1'b1) return k;
    return -1;
  endfunction

  function automatic int count_hi(input int sel, input int pad);
    int c = 0;
    for (int k = 1; k < LOGN; k++)
      if (lg[sel][k][pad] === 1'b1) c++;
    return c;
  endfunction

  function automatic logic [9:0] all_out();
    return {pressed, press_pulse, long_pulse, release_pulse, release_long};
  endfunction

  initial begin
    logic [9:0] acc;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'(all_out()), 32'd0);
    resetn = 1'b1;
    acc = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      acc = acc | all_out();
    end
    check("idle_100_cycles", 32'(acc), 32'd0);

    // ---- basic press (10 cycles) and release ----
    start();
    pad_n[0] = 1'b0;
    run(10);
    pad_n[0] = 1'b1;
    run(20);
    check("press_first_edge",   32'(first_hi(1, 0)), 32'd7);
    check("pressed_first_edge", 32'(first_hi(0, 0)), 32'd7);
    check("press_pulse_width",  32'(count_hi(1, 0)), 32'd1);
    check("release_edge",       32'(first_hi(3, 0)), 32'd17);
    check("release_count",      32'(count_hi(3, 0)), 32'd1);
    check("pressed_cycles",     32'(count_hi(0, 0)), 32'd10);
    check("short_release_long", 32'(lg[4][17][0]), 32'd0);
    check("short_no_long",      32'(count_hi(2, 0)), 32'd0);
    check("pad1_untouched",     32'(count_hi(0, 1) + count_hi(1, 1) + count_hi(3, 1)), 32'd0);

    // ---- glitches: 3 low / 3 high, five times ----
    start();
    for (int r = 0; r < 5; r++) begin
      pad_n[0] = 1'b0;
      run(3);
      pad_n[0] = 1'b1;
      run(3);
    end
    run(10);
    check("glitch_no_press",   32'(count_hi(1, 0)), 32'd0);
    check("glitch_no_pressed", 32'(count_hi(0, 0)), 32'd0);

    // ---- minimum accepted press: exactly 4 low samples ----
    start();
    pad_n[0] = 1'b0;
    run(4);
    pad_n[0] = 1'b1;
    run(16);
    check("min_press_edge",   32'(first_hi(1, 0)), 32'd7);
    check("min_release_edge", 32'(first_hi(3, 0)), 32'd11);

    // ---- long press: 40 cycles ----
    start();
    pad_n[0] = 1'b0;
    run(40);
    pad_n[0] = 1'b1;
    run(20);
    check("long_press_edge",   32'(first_hi(1, 0)), 32'd7);
    check("long_pulse_edge",   32'(first_hi(2, 0)), LP_EN ? 32'd27 : 32'hFFFF_FFFF);
    check("long_pulse_count",  32'(count_hi(2, 0)), LP_EN ? 32'd1 : 32'd0);
    check("long_release_edge", 32'(first_hi(3, 0)), 32'd47);
    check("long_release_long", 32'(lg[4][47][0]), LP_EN ? 32'd1 : 32'd0);
    check("release_long_only_with_release", 32'(count_hi(4, 0)), LP_EN ? 32'd1 : 32'd0);

    // ---- release and hold threshold in the same cycle: release wins ----
    start();
    pad_n[0] = 1'b0;
    run(20);
    pad_n[0] = 1'b1;
    run(20);
    check("tie_release_edge",  32'(first_hi(3, 0)), 32'd27);
    check("tie_no_long",       32'(count_hi(2, 0)), 32'd0);
    check("tie_release_long",  32'(lg[4][27][0]), 32'd0);

    // ---- one cycle longer: long fires, then release reports long ----
    start();
    pad_n[0] = 1'b0;
    run(21);
    pad_n[0] = 1'b1;
    run(20);
    check("edge_long_release", 32'(first_hi(3, 0)), 32'd28);
    check("edge_long_flag",    32'(lg[4][28][0]), LP_EN ? 32'd1 : 32'd0);

    // ---- both pads, reset mid-press ----
    start();
    pad_n = 2'b00;
    run(15);
    check("dual_press_pad0", 32'(first_hi(1, 0)), 32'd7);
    check("dual_press_pad1", 32'(first_hi(1, 1)), 32'd7);
    check("dual_pressed",    32'(lg[0][15]), 32'd3);
    resetn = 1'b0;
    #1;
    check("async_reset_clear", 32'(all_out()), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("in_reset_outputs", 32'(all_out()), 32'd0);
    resetn = 1'b1;
    start();
    run(12);
    check("repress_pad0",      32'(first_hi(1, 0)), 32'd7);
    check("repress_pad1",      32'(first_hi(1, 1)), 32'd7);
    check("no_release_reset",  32'(count_hi(3, 0) + count_hi(3, 1)), 32'd0);
    check("repress_pressed",   32'(first_hi(0, 0)), 32'd7);
    pad_n = 2'b11;
    run(15);
    check("dual_release_pad0", 32'(first_hi(3, 0)), 32'd19);
    check("dual_release_pad1", 32'(first_hi(3, 1)), 32'd19);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
